// File: rtl/frame_assembler_if.sv
// Sample-in / frame-out handshake bundle for frame_assembler.
// The master side drives samples and accepts frames; the slave side is the assembler.
interface frame_assembler_if #(
  parameter int SIZE  = 8,
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0]      sample_in;
  logic                  sample_valid;
  logic                  sample_ready;
  logic                  flush;
  logic [SIZE*WIDTH-1:0] frame_out;
  logic                  frame_valid;
  logic                  frame_ready;
  logic [7:0]            frame_seq;

  modport master (
    output sample_in, sample_valid, flush, frame_ready,
    input  sample_ready, frame_out, frame_valid, frame_seq
  );

  modport slave (
    input  sample_in, sample_valid, flush, frame_ready,
    output sample_ready, frame_out, frame_valid, frame_seq
  );
endinterface

// File: rtl/frame_assembler.sv
// Collects serial samples into SIZE-sample frames with HOP new samples between frames.
// Sample j of the frame sits at frame_out[j*WIDTH +: WIDTH], j=0 oldest.
module frame_assembler #(
  parameter int SIZE  = 8,
  parameter int WIDTH = 8,
  parameter int HOP   = 8
) (
  input logic             clk,
  input logic             rst,
  frame_assembler_if.slave bus
);

  if (HOP < 1 || HOP > SIZE) begin : g_bad_hop
    $error("frame_assembler: HOP=%0d must lie in 1..SIZE=%0d", HOP, SIZE);
  end

  localparam int CW = $clog2(SIZE + 1);
  localparam logic [CW-1:0] SIZE_C = CW'(SIZE);
  localparam logic [CW-1:0] HOP_C  = CW'(HOP);

  typedef enum logic [1:0] {FILL, HOLD, REFILL} state_t;

  state_t                state_q, state_d, base_state;
  logic [CW-1:0]         cnt_q, cnt_d, base_cnt, cnt_inc, need;
  logic [SIZE*WIDTH-1:0] shreg_q, shreg_d, base_reg, shifted;
  logic [7:0]            seq_q, seq_d;
  logic                  ready_q, valid_q;
  logic                  s_xfer, f_xfer;

  assign s_xfer = bus.sample_valid && ready_q;
  assign f_xfer = valid_q && bus.frame_ready;

  // Flush is folded in as a cleared starting point so a same-cycle sample still lands.
  always_comb begin
    base_state = bus.flush ? FILL : state_q;
    base_cnt   = bus.flush ? '0 : cnt_q;
    base_reg   = bus.flush ? '0 : shreg_q;
    state_d    = base_state;
    cnt_d      = base_cnt;
    shreg_d    = base_reg;
    seq_d      = seq_q;
    cnt_inc    = base_cnt + CW'(1);
    need       = (base_state == FILL) ? SIZE_C : HOP_C;
    shifted    = base_reg >> WIDTH;
    shifted[(SIZE-1)*WIDTH +: WIDTH] = bus.sample_in;

    case (base_state)
      FILL, REFILL: begin
        if (s_xfer) begin
          shreg_d = shifted;
          if (cnt_inc == need) begin
            state_d = HOLD;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      HOLD: begin
        if (f_xfer) begin
          state_d = REFILL;
          seq_d   = seq_q + 8'd1;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= FILL;
      cnt_q   <= '0;
      shreg_q <= '0;
      seq_q   <= '0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      seq_q   <= seq_d;
      ready_q <= (state_d != HOLD);
      valid_q <= (state_d == HOLD);
    end
  end

  assign bus.frame_out    = shreg_q;
  assign bus.frame_valid  = valid_q;
  assign bus.sample_ready = ready_q;
  assign bus.frame_seq    = seq_q;

endmodule

// File: tb/tb_frame_assembler.sv
// Scoreboard bench for frame_assembler (SIZE=8, WIDTH=8, HOP=4).
module tb_frame_assembler;
  localparam int SIZE  = 8;
  localparam int WIDTH = 8;
  localparam int HOP   = 4;
  localparam int FW    = SIZE * WIDTH;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  frame_assembler_if #(.SIZE(SIZE), .WIDTH(WIDTH)) bus ();

  frame_assembler #(.SIZE(SIZE), .WIDTH(WIDTH), .HOP(HOP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [FW-1:0] frame;
    logic [7:0]    seq;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   mon_en   = 1'b0;

  logic [7:0] mhist [SIZE];
  int         mcnt   = 0;
  bit         mfill  = 1'b1;
  bit         mvalid = 1'b0;
  bit         mready = 1'b0;
  logic [7:0] mseq   = '0;

  task tick();
    @(posedge clk);
    #1;
  endtask

  task model_loop();
    bit   sx, fx;
    exp_t e;
    forever begin
      @(posedge clk);
      sx = bus.sample_valid && mready;
      fx = mvalid && bus.frame_ready;
      if (!rst) begin
        if (mvalid && exp_q.size() > 0) void'(exp_q.pop_back());
        for (int j = 0; j < SIZE; j++) mhist[j] = '0;
        mcnt = 0; mfill = 1'b1; mvalid = 1'b0; mready = 1'b0; mseq = '0;
      end else begin
        if (bus.flush) begin
          if (mvalid && exp_q.size() > 0) void'(exp_q.pop_back());
          for (int j = 0; j < SIZE; j++) mhist[j] = '0;
          mcnt = 0; mfill = 1'b1; mvalid = 1'b0;
          if (sx) begin
            mhist[SIZE-1] = bus.sample_in;
            mcnt = 1;
          end
        end else if (sx) begin
          for (int j = 0; j < SIZE - 1; j++) mhist[j] = mhist[j+1];
          mhist[SIZE-1] = bus.sample_in;
          mcnt++;
          if (mcnt == (mfill ? SIZE : HOP)) begin
            mcnt = 0;
            mvalid = 1'b1;
            for (int j = 0; j < SIZE; j++) e.frame[j*WIDTH +: WIDTH] = mhist[j];
            e.seq = mseq;
            exp_q.push_back(e);
          end
        end else if (fx) begin
          mvalid = 1'b0;
          mfill  = 1'b0;
          mseq   = mseq + 8'd1;
        end
        mready = !mvalid;
      end
    end
  endtask

  task monitor_loop();
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        n_checks++;
        if (bus.sample_ready !== mready) begin
          n_fail++;
          $display("FAIL ready_track: sample_ready=%b expected %b at %0t", bus.sample_ready, mready, $time);
        end
        n_checks++;
        if (bus.frame_valid !== mvalid) begin
          n_fail++;
          $display("FAIL valid_track: frame_valid=%b expected %b at %0t", bus.frame_valid, mvalid, $time);
        end
        if (rst && !bus.flush && bus.frame_valid && bus.frame_ready) begin
          n_checks++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL frame_xfer: unexpected frame %h seq %0d, expected none", bus.frame_out, bus.frame_seq);
          end else begin
            e = exp_q.pop_front();
            if (bus.frame_out !== e.frame || bus.frame_seq !== e.seq) begin
              n_fail++;
              $display("FAIL frame_xfer: got %h seq %0d, expected %h seq %0d",
                       bus.frame_out, bus.frame_seq, e.frame, e.seq);
            end
          end
        end
      end
    end
  endtask

  task test_reset();
    bus.sample_in = '0; bus.sample_valid = 1'b0; bus.flush = 1'b0; bus.frame_ready = 1'b0;
    rst = 1'b0;
    repeat (3) tick();
    mon_en = 1'b1;
    n_checks++; if (bus.frame_out !== '0) begin n_fail++; $display("FAIL reset_frame: got %h expected 0", bus.frame_out); end
    n_checks++; if (bus.frame_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", bus.frame_valid); end
    n_checks++; if (bus.sample_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0", bus.sample_ready); end
    n_checks++; if (bus.frame_seq !== 8'd0) begin n_fail++; $display("FAIL reset_seq: got %0d expected 0", bus.frame_seq); end
    rst = 1'b1;
    tick();
    n_checks++; if (bus.sample_ready !== 1'b1) begin n_fail++; $display("FAIL release_ready: got %b expected 1", bus.sample_ready); end
  endtask

  task test_fill();
    logic [FW-1:0] exp;
    for (int j = 0; j < SIZE; j++) exp[j*WIDTH +: WIDTH] = 8'(j + 1);
    bus.frame_ready = 1'b0;
    for (int i = 1; i <= SIZE; i++) begin
      bus.sample_valid = 1'b1;
      bus.sample_in = 8'(i);
      tick();
      if (i == SIZE - 1) begin
        n_checks++; if (bus.frame_valid !== 1'b0) begin n_fail++; $display("FAIL fill_early: frame_valid=%b expected 0", bus.frame_valid); end
      end
    end
    n_checks++; if (bus.frame_valid !== 1'b1) begin n_fail++; $display("FAIL fill_valid: got %b expected 1", bus.frame_valid); end
    n_checks++; if (bus.sample_ready !== 1'b0) begin n_fail++; $display("FAIL fill_ready: got %b expected 0", bus.sample_ready); end
    n_checks++; if (bus.frame_seq !== 8'd0) begin n_fail++; $display("FAIL fill_seq: got %0d expected 0", bus.frame_seq); end
    n_checks++; if (bus.frame_out !== exp) begin n_fail++; $display("FAIL fill_frame: got %h expected %h", bus.frame_out, exp); end
  endtask

  task test_backpressure();
    logic [FW-1:0] snap, exp;
    snap = bus.frame_out;
    bus.sample_valid = 1'b1; bus.sample_in = 8'd9; bus.frame_ready = 1'b0;
    repeat (5) begin
      tick();
      n_checks++; if (bus.frame_out !== snap) begin n_fail++; $display("FAIL bp_stable: got %h expected %h", bus.frame_out, snap); end
      n_checks++; if (bus.sample_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready: got %b expected 0", bus.sample_ready); end
    end
    bus.frame_ready = 1'b1;
    tick();
    bus.frame_ready = 1'b0;
    n_checks++; if (bus.frame_seq !== 8'd1) begin n_fail++; $display("FAIL bp_seq: got %0d expected 1", bus.frame_seq); end
    n_checks++; if (bus.sample_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release: got %b expected 1", bus.sample_ready); end
    tick();
    n_checks++; if (bus.frame_out[FW-1 -: WIDTH] !== 8'd9) begin n_fail++; $display("FAIL bp_next: entry7=%0d expected 9", bus.frame_out[FW-1 -: WIDTH]); end
    for (int v = 10; v <= 12; v++) begin
      bus.sample_in = 8'(v);
      tick();
    end
    for (int j = 0; j < SIZE; j++) exp[j*WIDTH +: WIDTH] = 8'(j + 5);
    n_checks++; if (bus.frame_out !== exp) begin n_fail++; $display("FAIL bp_refill: got %h expected %h", bus.frame_out, exp); end
    bus.sample_valid = 1'b0; bus.frame_ready = 1'b1;
    tick();
    bus.frame_ready = 1'b0;
  endtask

  task test_hop_stream();
    int  v, lows, accepted;
    bit  acc;
    rst = 1'b0; tick(); rst = 1'b1; tick();
    bus.frame_ready = 1'b1;
    v = 1; lows = 0; accepted = 0;
    for (int cyc = 0; cyc < 40 && accepted < 12; cyc++) begin
      bus.sample_valid = 1'b1;
      bus.sample_in = 8'(v);
      @(negedge clk);
      acc = bus.sample_ready;
      if (!acc) lows++;
      tick();
      if (acc) begin v++; accepted++; end
    end
    bus.sample_valid = 1'b0;
    @(negedge clk);
    if (!bus.sample_ready) lows++;
    tick();
    bus.frame_ready = 1'b0;
    n_checks++; if (accepted != 12) begin n_fail++; $display("FAIL hop_accept: accepted %0d expected 12", accepted); end
    n_checks++; if (lows != 2) begin n_fail++; $display("FAIL hop_stall: ready low %0d cycles expected 2", lows); end
    n_checks++; if (bus.frame_seq !== 8'd2) begin n_fail++; $display("FAIL hop_seq: got %0d expected 2", bus.frame_seq); end
  endtask

  task test_flush();
    logic [FW-1:0] exp;
    rst = 1'b0; tick(); rst = 1'b1; tick();
    bus.frame_ready = 1'b0; bus.sample_valid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      bus.sample_in = 8'(8'h10 + i);
      tick();
    end
    bus.flush = 1'b1; bus.sample_in = 8'hAA;
    tick();
    bus.flush = 1'b0;
    exp = '0;
    exp[FW-1 -: WIDTH] = 8'hAA;
    n_checks++; if (bus.frame_out !== exp) begin n_fail++; $display("FAIL flush_clear: got %h expected %h", bus.frame_out, exp); end
    for (int i = 1; i <= 7; i++) begin
      bus.sample_in = 8'(i);
      tick();
      if (i == 6) begin
        n_checks++; if (bus.frame_valid !== 1'b0) begin n_fail++; $display("FAIL flush_early: frame_valid=%b expected 0", bus.frame_valid); end
      end
    end
    exp[0 +: WIDTH] = 8'hAA;
    for (int j = 1; j < SIZE; j++) exp[j*WIDTH +: WIDTH] = 8'(j);
    n_checks++; if (bus.frame_valid !== 1'b1) begin n_fail++; $display("FAIL flush_valid: got %b expected 1", bus.frame_valid); end
    n_checks++; if (bus.frame_out !== exp) begin n_fail++; $display("FAIL flush_frame: got %h expected %h", bus.frame_out, exp); end
    bus.sample_valid = 1'b0; bus.flush = 1'b1; bus.frame_ready = 1'b1;
    tick();
    bus.flush = 1'b0; bus.frame_ready = 1'b0;
    n_checks++; if (bus.frame_valid !== 1'b0) begin n_fail++; $display("FAIL flush_drop: frame_valid=%b expected 0", bus.frame_valid); end
    n_checks++; if (bus.frame_seq !== 8'd0) begin n_fail++; $display("FAIL flush_seq: got %0d expected 0", bus.frame_seq); end
    n_checks++; if (bus.frame_out !== '0) begin n_fail++; $display("FAIL flush_zero: got %h expected 0", bus.frame_out); end
  endtask

  task test_reset_in_hold();
    bus.frame_ready = 1'b0; bus.sample_valid = 1'b1;
    for (int i = 0; i < SIZE; i++) begin bus.sample_in = 8'(8'h21 + i); tick(); end
    bus.frame_ready = 1'b1; tick(); bus.frame_ready = 1'b0;
    for (int i = 0; i < HOP; i++) begin bus.sample_in = 8'(8'h41 + i); tick(); end
    n_checks++; if (bus.frame_valid !== 1'b1 || bus.frame_seq !== 8'd1) begin
      n_fail++; $display("FAIL rh_setup: valid=%b seq=%0d expected 1 and 1", bus.frame_valid, bus.frame_seq);
    end
    rst = 1'b0;
    tick();
    n_checks++; if (bus.frame_valid !== 1'b0) begin n_fail++; $display("FAIL rh_valid: got %b expected 0", bus.frame_valid); end
    n_checks++; if (bus.frame_out !== '0) begin n_fail++; $display("FAIL rh_frame: got %h expected 0", bus.frame_out); end
    n_checks++; if (bus.frame_seq !== 8'd0) begin n_fail++; $display("FAIL rh_seq: got %0d expected 0", bus.frame_seq); end
    n_checks++; if (bus.sample_ready !== 1'b0) begin n_fail++; $display("FAIL rh_ready: got %b expected 0", bus.sample_ready); end
    rst = 1'b1;
    tick();
    for (int i = 1; i <= SIZE; i++) begin
      bus.sample_in = 8'(8'h60 + i);
      tick();
      if (i == SIZE - 1) begin
        n_checks++; if (bus.frame_valid !== 1'b0) begin n_fail++; $display("FAIL rh_refill_early: frame_valid=%b expected 0", bus.frame_valid); end
      end
    end
    n_checks++; if (bus.frame_valid !== 1'b1) begin n_fail++; $display("FAIL rh_refill: frame_valid=%b expected 1", bus.frame_valid); end
    bus.sample_valid = 1'b0; bus.frame_ready = 1'b1;
    tick();
    bus.frame_ready = 1'b0;
  endtask

  task test_seq_wrap();
    int k;
    rst = 1'b0; tick(); rst = 1'b1; tick();
    bus.frame_ready = 1'b1; bus.sample_valid = 1'b1;
    k = 0;
    for (int cyc = 0; cyc < 4000 && k < 257; cyc++) begin
      bus.sample_in = 8'($urandom);
      @(negedge clk);
      if (bus.frame_valid && bus.frame_ready) begin
        n_checks++;
        if (bus.frame_seq !== 8'(k)) begin
          n_fail++; $display("FAIL wrap_seq: frame %0d seq=%0d expected %0d", k, bus.frame_seq, k % 256);
        end
        k++;
      end
      tick();
    end
    n_checks++; if (k != 257) begin n_fail++; $display("FAIL wrap_count: saw %0d frames expected 257", k); end
    n_checks++; if (bus.frame_seq !== 8'd1) begin n_fail++; $display("FAIL wrap_final: seq=%0d expected 1", bus.frame_seq); end
    bus.sample_valid = 1'b0;
    repeat (3) tick();
    bus.frame_ready = 1'b0;
  endtask

  initial begin
    fork
      model_loop();
      monitor_loop();
    join_none
    test_reset();
    test_fill();
    test_backpressure();
    test_hop_stream();
    test_flush();
    test_reset_in_hold();
    test_seq_wrap();
    tick();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_drain: %0d frames outstanding expected 0", exp_q.size());
    end
    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
